// File: rtl/spi_scheduler_pkg.sv
// Shared types and constants for the SPI channel scheduler.
package spi_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int unsigned SPI_WORD_W  = 24;
  localparam int unsigned SPI_DEPTH_W = 8;

  localparam logic CH_ADF4002 = 1'b0;
  localparam logic CH_LMX2594 = 1'b1;

  function automatic logic [1:0] ch_onehot(input logic tgt);
    return (tgt == CH_LMX2594) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_scheduler_arbiter.sv
// Combinational round-robin arbiter: search starts one above last_grant.
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  int unsigned cand;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(last_grant) + i) % N;
      if (!found && req[IDX_W'(cand)]) begin
        found                 = 1'b1;
        grant[IDX_W'(cand)]   = 1'b1;
        grant_idx             = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/spi_scheduler.sv
// Round-robin scheduler launching one 24-bit write at a time onto two SPI masters.
// Optional transfer watchdog: define SPI_SCHED_TIMEOUT_EN.
module spi_scheduler
  import spi_sched_pkg::*;
#(
  parameter int unsigned NREQ           = 3,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0]             req_target,
  input  logic [NREQ-1:0]             req_dir,
  input  logic [NREQ*SPI_WORD_W-1:0]  req_data,
  input  logic [NREQ*SPI_DEPTH_W-1:0] req_depth,
  output logic [NREQ-1:0]             req_ready,
  output logic [NREQ-1:0]             req_done,
  input  logic [1:0]                  spi_ready,
  output logic [1:0]                  spi_start,
  output logic                        spi_dir,
  output logic [SPI_WORD_W-1:0]       spi_data_tx,
  output logic [SPI_DEPTH_W-1:0]      spi_data_depth,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state;
  logic             cur_tgt;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] grant_idx;
  logic [NREQ-1:0]  grant;
  logic             wd_hit;

  rr_arbiter #(.N(NREQ), .IDX_W(IDX_W)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready = (state == IDLE) ? grant : '0;
  assign busy      = (state != IDLE);

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;
  assign wd_hit = (state != IDLE) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= IDX_W'(NREQ - 1);
      cur_idx        <= '0;
      cur_tgt        <= 1'b0;
      spi_start      <= '0;
      spi_dir        <= 1'b0;
      spi_data_tx    <= '0;
      spi_data_depth <= '0;
      req_done       <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
      timeout_err    <= 1'b0;
      wd_cnt         <= '0;
`endif
    end else begin
      req_done <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
      timeout_err <= 1'b0;
      if (state != IDLE) wd_cnt <= wd_cnt + 1'b1;
`endif
      // Watchdog abort overrides whatever the current state would do.
      if (wd_hit) begin
        spi_start         <= '0;
        req_done[cur_idx] <= 1'b1;
        state             <= IDLE;
`ifdef SPI_SCHED_TIMEOUT_EN
        timeout_err       <= 1'b1;
`endif
      end else begin
        unique case (state)
          IDLE: begin
            if (|grant) begin
              cur_idx        <= grant_idx;
              last_grant     <= grant_idx;
              cur_tgt        <= req_target[grant_idx];
              spi_dir        <= req_dir[grant_idx];
              spi_data_tx    <= req_data[int'(grant_idx)*SPI_WORD_W +: SPI_WORD_W];
              spi_data_depth <= req_depth[int'(grant_idx)*SPI_DEPTH_W +: SPI_DEPTH_W];
              state          <= LAUNCH;
`ifdef SPI_SCHED_TIMEOUT_EN
              wd_cnt         <= '0;
`endif
            end
          end
          LAUNCH: begin
            if (spi_ready[cur_tgt]) begin
              spi_start <= ch_onehot(cur_tgt);
              state     <= WAIT_BUSY;
            end
          end
          WAIT_BUSY: begin
            spi_start <= '0;
            if (!spi_ready[cur_tgt]) state <= WAIT_DONE;
          end
          WAIT_DONE: begin
            if (spi_ready[cur_tgt]) begin
              req_done[cur_idx] <= 1'b1;
              state             <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_scheduler.sv
// Directed bench for spi_scheduler with a simple two-channel SPI master model.
module tb_spi_scheduler;

  localparam int unsigned NREQ = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [NREQ-1:0]     req_valid, req_target, req_dir;
  logic [NREQ*24-1:0]  req_data;
  logic [NREQ*8-1:0]   req_depth;
  logic [NREQ-1:0]     req_ready, req_done;
  logic [1:0]          spi_ready, spi_start;
  logic                spi_dir;
  logic [23:0]         spi_data_tx;
  logic [7:0]          spi_data_depth;
  logic                busy, timeout_err;

  logic [1:0]  mdl_rdy;
  logic [1:0]  blk;
  logic [1:0]  stuck;
  int unsigned mdl_cnt [2];

  int n_chk = 0;
  int n_bad = 0;
  int done_total = 0;

  spi_scheduler #(.NREQ(NREQ), .TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_target     (req_target),
    .req_dir        (req_dir),
    .req_data       (req_data),
    .req_depth      (req_depth),
    .req_ready      (req_ready),
    .req_done       (req_done),
    .spi_ready      (spi_ready),
    .spi_start      (spi_start),
    .spi_dir        (spi_dir),
    .spi_data_tx    (spi_data_tx),
    .spi_data_depth (spi_data_depth),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  // Master model: ready drops the edge after start, returns three edges later.
  assign spi_ready = mdl_rdy & ~blk;

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        mdl_rdy[c] <= 1'b1;
        mdl_cnt[c] <= 0;
      end else if (spi_start[c]) begin
        mdl_rdy[c] <= 1'b0;
        mdl_cnt[c] <= 3;
      end else if (!mdl_rdy[c] && !stuck[c]) begin
        if (mdl_cnt[c] == 1) mdl_rdy[c] <= 1'b1;
        mdl_cnt[c] <= mdl_cnt[c] - 1;
      end
    end
  end

  always @(posedge clk) done_total <= done_total + $countones(req_done);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int unsigned k, input logic tgt, input logic dir,
                         input logic [23:0] data, input logic [7:0] depth);
    req_target[k]        = tgt;
    req_dir[k]           = dir;
    req_data[k*24 +: 24] = data;
    req_depth[k*8 +: 8]  = depth;
  endtask

  task automatic wait_done(input int unsigned budget, output int unsigned cyc,
                           output logic [NREQ-1:0] val);
    cyc = 0;
    val = '0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (req_done != '0) begin
        val = req_done;
        break;
      end
    end
  endtask

  initial begin
    int unsigned     cyc;
    int unsigned     starts;
    int unsigned     base;
    logic [NREQ-1:0] val;
    logic [23:0]     fair_data [3];
    logic [31:0]     exp_oh;

    rst_n      = 1'b0;
    req_valid  = '0;
    req_target = '0;
    req_dir    = '0;
    req_data   = '0;
    req_depth  = '0;
    blk        = '0;
    stuck      = '0;
    tick(3);

    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_done", 32'(req_done), 32'h0);
    check("rst_start", 32'(spi_start), 32'h0);
    check("rst_dir", 32'(spi_dir), 32'h0);
    check("rst_data", 32'(spi_data_tx), 32'h0);
    check("rst_depth", 32'(spi_data_depth), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_toerr", 32'(timeout_err), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single request from requester 1 to channel 1
    base = done_total;
    set_req(1, 1'b1, 1'b1, 24'h00A5C3, 8'd24);
    req_valid = 3'b010;
    #1;
    check("single_ready", 32'(req_ready), 32'h2);
    tick();
    check("single_busy", 32'(busy), 32'h1);
    check("single_launch_start", 32'(spi_start), 32'h0);
    check("single_data", 32'(spi_data_tx), 32'h00A5C3);
    check("single_depth", 32'(spi_data_depth), 32'd24);
    check("single_dir", 32'(spi_dir), 32'h1);
    check("single_ready_launch", 32'(req_ready), 32'h0);
    req_valid = '0;
    tick();
    check("single_start", 32'(spi_start), 32'h2);
    tick();
    check("single_start_off", 32'(spi_start), 32'h0);
    wait_done(20, cyc, val);
    check("single_done_cyc", 32'(3 + cyc), 32'd7);
    check("single_done", 32'(val), 32'h2);
    tick();
    check("single_done_pulse", 32'(req_done), 32'h0);
    check("single_idle", 32'(busy), 32'h0);
    check("single_hold", 32'(spi_data_tx), 32'h00A5C3);
    check("single_done_cnt", 32'(done_total - base), 32'd1);

    // Blocked target: channel 0 not ready, channel 1 ready toggling
    base = done_total;
    blk[0] = 1'b1;
    set_req(0, 1'b0, 1'b0, 24'h123456, 8'd16);
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    starts = 0;
    repeat (20) begin
      blk[1] = ~blk[1];
      tick();
      if (spi_start != '0) starts++;
    end
    check("blk_nostart", 32'(starts), 32'd0);
    check("blk_busy", 32'(busy), 32'h1);
    check("blk_data", 32'(spi_data_tx), 32'h123456);
    blk = '0;
    tick();
    check("blk_start", 32'(spi_start), 32'h1);
    wait_done(20, cyc, val);
    check("blk_done", 32'(val), 32'h1);
    tick();
    check("blk_done_cnt", 32'(done_total - base), 32'd1);

    // Reset while waiting for completion
    set_req(1, 1'b0, 1'b1, 24'h0F0F0F, 8'd12);
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    tick(3);
    check("rmid_busy_before", 32'(busy), 32'h1);
    base = done_total;
    rst_n = 1'b0;
    tick();
    check("rmid_busy", 32'(busy), 32'h0);
    check("rmid_start", 32'(spi_start), 32'h0);
    check("rmid_data", 32'(spi_data_tx), 32'h0);
    check("rmid_depth", 32'(spi_data_depth), 32'h0);
    check("rmid_dir", 32'(spi_dir), 32'h0);
    check("rmid_done", 32'(req_done), 32'h0);
    rst_n = 1'b1;
    tick(6);
    check("rmid_no_done", 32'(done_total - base), 32'd0);

    // Fairness: all valid continuously right after reset
    base = done_total;
    fair_data[0] = 24'h111111;
    fair_data[1] = 24'h222222;
    fair_data[2] = 24'h333333;
    set_req(0, 1'b0, 1'b0, fair_data[0], 8'd8);
    set_req(1, 1'b1, 1'b1, fair_data[1], 8'd16);
    set_req(2, 1'b0, 1'b1, fair_data[2], 8'd24);
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      wait_done(30, cyc, val);
      exp_oh = 32'h1 << (i % 3);
      check($sformatf("fair_grant%0d", i), 32'(val), exp_oh);
      check($sformatf("fair_data%0d", i), 32'(spi_data_tx), 32'(fair_data[i % 3]));
    end
    req_valid = '0;
    tick(10);
    check("fair_done_cnt", 32'(done_total - base), 32'd6);
    check("fair_idle", 32'(busy), 32'h0);

    // Master that never restores ready
    stuck[1] = 1'b1;
    set_req(2, 1'b1, 1'b0, 24'hABCDEF, 8'd24);
    req_valid = 3'b100;
`ifdef SPI_SCHED_TIMEOUT_EN
    cyc = 0;
    while (cyc < 40) begin
      tick();
      cyc++;
      if (cyc == 1) req_valid = '0;
      if (timeout_err) break;
    end
    check("wd_cyc", 32'(cyc), 32'd17);
    check("wd_done", 32'(req_done), 32'h4);
    tick();
    check("wd_idle", 32'(busy), 32'h0);
    check("wd_pulse", 32'(timeout_err), 32'h0);
`else
    tick();
    req_valid = '0;
    starts = 0;
    repeat (40) begin
      tick();
      if (!busy || timeout_err) starts++;
    end
    check("stuck_held", 32'(starts), 32'd0);
    check("stuck_busy", 32'(busy), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
